sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 11, data word width in bits.
REQ-002 Parameter DEPTH, default 7, pointer width in bits; capacity SHALL be 2**DEPTH words.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  WIDTH  word to enqueue.
REQ-006 push  input  1  enqueue request, sampled at the clk rising edge.
REQ-007 pop  input  1  dequeue request, sampled at the clk rising edge.
REQ-008 q  output  WIDTH  registered output holding the most recently dequeued word.
REQ-009 q_valid  output  1  high for exactly the one cycle after an accepted pop.
REQ-010 full  output  1  high when count equals 2**DEPTH.
REQ-011 empty  output  1  high when count equals 0.
REQ-012 count  output  DEPTH+1  number of stored words.
REQ-013 overflow  output  1  sticky error flag for a rejected push.
REQ-014 underflow  output  1  sticky error flag for a rejected pop.

Function
REQ-015 Ordering SHALL be first-in-first-out: words leave in the order they were accepted.
REQ-016 Storage SHALL be a 2**DEPTH x WIDTH array with a DEPTH-bit write pointer (wr_ptr) and a DEPTH-bit read pointer (rd_ptr).
REQ-017 Both pointers SHALL wrap modulo 2**DEPTH without special-case logic.
REQ-018 A push SHALL be accepted when push=1 and either full=0, or full=1 with pop=1 in the same cycle.
REQ-019 An accepted push SHALL write data_in to mem[wr_ptr] and increment wr_ptr.
REQ-020 A pop SHALL be accepted when pop=1 and empty=0.
REQ-021 An accepted pop SHALL load q with mem[rd_ptr], increment rd_ptr and set q_valid=1 for the next cycle.
REQ-022 Pop latency: for a pop accepted at edge N, q and q_valid SHALL be valid immediately after edge N; q SHALL hold its value until the next accepted pop.
REQ-023 q_valid SHALL be 0 in every cycle that does not follow an accepted pop.
REQ-024 Write-to-read latency: a word pushed at edge N into an empty FIFO SHALL be poppable at edge N+1 (empty=0 after edge N).
REQ-025 count update: +1 for a push-only accept, -1 for a pop-only accept, unchanged when both or neither are accepted.
REQ-026 full, empty and count SHALL be registered and consistent with each other after every edge.
REQ-027 Simultaneous push and pop while empty: the push SHALL be accepted, the pop rejected, underflow set, and count set to 1.
REQ-028 Simultaneous push and pop while full: both SHALL be accepted, count SHALL stay 2**DEPTH, and q SHALL receive the oldest word.
REQ-029 A push while full without pop SHALL be dropped: memory and pointers unchanged, overflow set to 1.
REQ-030 A pop while empty SHALL be rejected: q unchanged, q_valid=0, underflow set to 1.
REQ-031 overflow and underflow SHALL remain 1 until reset.

Reset
REQ-032 reset=1 SHALL immediately, without waiting for a clk edge, force wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, q=0, q_valid=0, overflow=0 and underflow=0.
REQ-033 Memory contents SHALL NOT be cleared by reset; the contents are unobservable because empty=1.
REQ-034 Reset asserted mid-operation SHALL discard all stored words.
REQ-035 push and pop SHALL be ignored on the first rising edge at which reset is low.

Verification
REQ-036 Reset, then push 3, 5, 7 on three edges, then pop three times -> q = 3, 5, 7 on successive cycles with q_valid=1, then empty=1 and count=0.
REQ-037 DEPTH=2: push 4 words -> full=1, count=4; a 5th push -> overflow=1, and 4 pops return the original 4 words in order.
REQ-038 Pop on an empty FIFO -> underflow=1, q unchanged, q_valid=0; push and pop together while empty -> count=1, underflow=1.
REQ-039 Full FIFO with push and pop in the same cycle -> count stays 4, q = oldest word, and the new word is dequeued last.
REQ-040 DEPTH=2: 10 push/pop cycles with data 0..9 -> pointers wrap and output order is 0..9 with no loss.
REQ-041 Assert reset asynchronously between edges while count=3 -> all outputs take their reset values before the next edge, and a subsequent pop -> underflow=1.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO of 2**DEPTH words with a registered read port, registered
// status flags and sticky overflow/underflow error flags.
module sync_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             push,
   input  logic             pop,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             full,
   output logic             empty,
   output logic [DEPTH:0]   count,
   output logic             overflow,
   output logic             underflow
);

   localparam int CAP = 2 ** DEPTH;

   logic [WIDTH-1:0] r_mem [CAP];
   logic [DEPTH-1:0] r_wr_ptr;
   logic [DEPTH-1:0] r_rd_ptr;
   logic [DEPTH:0]   r_count;
   logic             r_full;
   logic             r_empty;
   logic [WIDTH-1:0] r_q;
   logic             r_q_valid;
   logic             r_overflow;
   logic             r_underflow;
   logic             r_armed;

   logic             w_push_ok;
   logic             w_pop_ok;
   logic [DEPTH:0]   w_count_nxt;

   // r_armed keeps the first edge after reset release from accepting traffic.
   assign w_push_ok = r_armed & push & (~r_full | pop);
   assign w_pop_ok  = r_armed & pop & ~r_empty;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push_ok, w_pop_ok})
         2'b10:   w_count_nxt = r_count + (DEPTH+1)'(1);
         2'b01:   w_count_nxt = r_count - (DEPTH+1)'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Storage is deliberately left out of reset; empty hides stale contents.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
         r_q         <= '0;
         r_q_valid   <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_armed     <= 1'b0;
      end else begin
         r_armed   <= 1'b1;
         r_q_valid <= w_pop_ok;
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + DEPTH'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + DEPTH'(1);
            r_q      <= r_mem[r_rd_ptr];
         end
         // Only a count of exactly 2**DEPTH sets the top bit.
         r_count <= w_count_nxt;
         r_full  <= w_count_nxt[DEPTH];
         r_empty <= (w_count_nxt == '0);
         if (r_armed && push && r_full && !pop) begin
            r_overflow <= 1'b1;
         end
         if (r_armed && pop && r_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign q         = r_q;
   assign q_valid   = r_q_valid;
   assign full      = r_full;
   assign empty     = r_empty;
   assign count     = r_count;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo with DEPTH=2 (four-word capacity).
module tb_sync_fifo;

   localparam int WIDTH = 11;
   localparam int DEPTH = 2;

   logic             clk;
   logic             reset;
   logic [WIDTH-1:0] data_in;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] q;
   logic             q_valid;
   logic             full;
   logic             empty;
   logic [DEPTH:0]   count;
   logic             overflow;
   logic             underflow;

   int n_checks = 0;
   int n_fail   = 0;

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .push      (push),
      .pop       (pop),
      .q         (q),
      .q_valid   (q_valid),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within time budget");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic p, input logic r, input logic [WIDTH-1:0] d);
      push    = p;
      pop     = r;
      data_in = d;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " count"},     32'(count),     32'd0);
      check({tag, " empty"},     32'(empty),     32'd1);
      check({tag, " full"},      32'(full),      32'd0);
      check({tag, " q"},         32'(q),         32'd0);
      check({tag, " q_valid"},   32'(q_valid),   32'd0);
      check({tag, " overflow"},  32'(overflow),  32'd0);
      check({tag, " underflow"}, 32'(underflow), 32'd0);
   endtask

   // Pulse reset, release it, and let the ignored first edge pass.
   task automatic do_reset();
      drive(1'b0, 1'b0, '0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   int exp_words[4] = '{11, 12, 13, 20};

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, '0);
      tick();
      tick();
      check_reset_state("rst");

      // First edge after release must ignore a push.
      reset = 1'b0;
      drive(1'b1, 1'b0, 11'd99);
      tick();
      check("arm count", 32'(count), 32'd0);
      check("arm empty", 32'(empty), 32'd1);

      // Push 3,5,7 then pop three times.
      drive(1'b1, 1'b0, 11'd3); tick();
      check("wr1 empty", 32'(empty), 32'd0);
      drive(1'b1, 1'b0, 11'd5); tick();
      drive(1'b1, 1'b0, 11'd7); tick();
      check("wr3 count", 32'(count), 32'd3);
      drive(1'b0, 1'b1, '0); tick();
      check("rd1 q", 32'(q), 32'd3);
      check("rd1 q_valid", 32'(q_valid), 32'd1);
      tick();
      check("rd2 q", 32'(q), 32'd5);
      check("rd2 q_valid", 32'(q_valid), 32'd1);
      tick();
      check("rd3 q", 32'(q), 32'd7);
      check("rd3 q_valid", 32'(q_valid), 32'd1);
      check("rd3 empty", 32'(empty), 32'd1);
      check("rd3 count", 32'(count), 32'd0);
      drive(1'b0, 1'b0, '0); tick();
      check("idle q_valid", 32'(q_valid), 32'd0);
      check("idle q hold", 32'(q), 32'd7);

      // Underflow on empty pop, then push+pop together while empty.
      drive(1'b0, 1'b1, '0); tick();
      check("udf flag", 32'(underflow), 32'd1);
      check("udf q", 32'(q), 32'd7);
      check("udf q_valid", 32'(q_valid), 32'd0);
      drive(1'b1, 1'b1, 11'h55); tick();
      check("pp_empty count", 32'(count), 32'd1);
      check("pp_empty udf", 32'(underflow), 32'd1);
      check("pp_empty q_valid", 32'(q_valid), 32'd0);
      drive(1'b0, 1'b1, '0); tick();
      check("pp_empty pop q", 32'(q), 32'h55);
      check("pp_empty pop count", 32'(count), 32'd0);
      drive(1'b0, 1'b0, '0); tick();
      check("udf sticky", 32'(underflow), 32'd1);

      // Fill, overflow, push+pop while full, drain.
      do_reset();
      check_reset_state("rst2");
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 11'(10 + i));
         tick();
      end
      check("fill full", 32'(full), 32'd1);
      check("fill count", 32'(count), 32'd4);
      check("fill ovf clear", 32'(overflow), 32'd0);
      drive(1'b1, 1'b0, 11'd14); tick();
      check("ovf flag", 32'(overflow), 32'd1);
      check("ovf count", 32'(count), 32'd4);
      drive(1'b1, 1'b1, 11'd20); tick();
      check("pp_full q", 32'(q), 32'd10);
      check("pp_full q_valid", 32'(q_valid), 32'd1);
      check("pp_full count", 32'(count), 32'd4);
      check("pp_full full", 32'(full), 32'd1);
      drive(1'b0, 1'b1, '0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("drain q%0d", i), 32'(q), 32'(exp_words[i]));
      end
      check("drain empty", 32'(empty), 32'd1);
      check("ovf sticky", 32'(overflow), 32'd1);
      drive(1'b0, 1'b0, '0); tick();

      // Streaming 0..9 through a four-entry FIFO wraps both pointers.
      do_reset();
      drive(1'b1, 1'b0, 11'd0); tick();
      for (int i = 1; i < 10; i++) begin
         drive(1'b1, 1'b1, 11'(i));
         tick();
         check($sformatf("wrap q%0d", i - 1), 32'(q), 32'(i - 1));
         check($sformatf("wrap count%0d", i), 32'(count), 32'd1);
      end
      drive(1'b0, 1'b1, '0); tick();
      check("wrap q9", 32'(q), 32'd9);
      check("wrap empty", 32'(empty), 32'd1);

      // Asynchronous reset between edges with three words stored.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 11'(40 + i));
         tick();
      end
      drive(1'b0, 1'b0, '0);
      check("pre_arst count", 32'(count), 32'd3);
      check("pre_arst q", 32'(q), 32'd9);
      #4;
      reset = 1'b1;
      #1;
      check_reset_state("arst");
      #1;
      reset = 1'b0;
      tick();
      drive(1'b0, 1'b1, '0); tick();
      check("arst pop udf", 32'(underflow), 32'd1);
      check("arst pop q_valid", 32'(q_valid), 32'd0);
      check("arst pop count", 32'(count), 32'd0);
      drive(1'b0, 1'b0, '0); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
